spi_master: RTL
===============

// Module: spi_master
// PURPOSE
//  SPI master for the SPI slave/RAM subsystem. Takes a 10-bit command word from a host and drives one
//  frame: SS_n low, command preview, 10 bits on MOSI MSB-first at one bit per clk.
//  For read-data frames (cmd 2'b11) it then samples 8 bits from MISO and returns them to the host.
//  Sits between host logic and the SS_n/MOSI/MISO pins of the slave.
// PARAMETERS
//  FRAME_W     10  bits shifted out per frame: {cmd[1:0], payload[7:0]}
//  DATA_W      8   bits returned on MISO for a read-data frame
//  TURNAROUND  2   idle clk cycles after last MOSI bit before first MISO bit (slave RAM read latency)
//  GAP         1   minimum cycles SS_n stays high between frames
// PORTS
//  clk       in   1        system clock; SPI bit clock is clk itself
//  rst       in   1        synchronous, active-high reset
//  start     in   1        host request; accepted only when busy==0
//  tx_word   in   FRAME_W  command word, sampled on the accepting edge
//  busy      out  1        frame or inter-frame gap in progress
//  done      out  1        1-cycle pulse, frame complete
//  rd_data   out  DATA_W   data read back; holds until next read-data frame completes
//  rd_valid  out  1        1-cycle pulse with done, read-data frames only
//  SS_n      out  1        slave select, active low
//  MOSI      out  1        serial data to slave
//  MISO      in   1        serial data from slave
// BEHAVIOUR
//  Reset (sync, rst=1 at edge): SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, state IDLE,
//   counters 0. All outputs are registered.
//  Commands (tx_word[9:8]): 00 write addr, 01 write data, 10 read addr, 11 read data.
//  States:
//   IDLE : SS_n=1, busy=0. start=1 -> latch tx_word into shift reg, busy=1, go START.
//   START: 1 cycle, SS_n=0, MOSI=tx_word[9] (preview for slave command check) -> SEND.
//   SEND : FRAME_W cycles, MOSI=word[9-i] for i=0..9 -> cmd==11 ? TURN : FINISH.
//   TURN : TURNAROUND cycles, SS_n=0, MOSI=0 -> RECV.
//   RECV : DATA_W cycles, SS_n=0. MISO sampled each rising edge, shifted in MSB-first -> FINISH.
//   FINISH: SS_n=1, done=1. rd_data updated and rd_valid=1 if cmd==11 -> GAP.
//   GAP  : SS_n=1, busy=1 for GAP-1 further cycles (none if GAP==1) -> IDLE.
//  SS_n low duration: 1+FRAME_W = 11 cycles for cmds 00/01/10;
//   1+FRAME_W+TURNAROUND+DATA_W = 21 cycles for cmd 11 (defaults).
//  busy rises the cycle after start is accepted; falls on entry to IDLE.
//   start while busy=1 is dropped, not queued.
//  Earliest next SS_n fall is GAP cycles after the FINISH cycle.
//  rst during any state: next edge forces reset values; SS_n high immediately.
//   No done/rd_valid for the aborted frame; rd_data cleared.
//  Bit counter width $clog2(FRAME_W+1); it is reused for TURN/RECV/GAP and reloaded on each
//   state entry, with no wrap.
//  MISO ignored outside RECV. tx_word ignored except on the accepting edge.
// STRUCTURE
//  spi_pkg: cmd codes CMD_WR_ADDR/CMD_WR_DATA/CMD_RD_ADDR/CMD_RD_DATA, state enum, FRAME_W/DATA_W defaults.
//   The SPI slave imports the same package.
//  Single module, no sub-module: FSM, one down-counter, 10-bit TX shift reg, 8-bit RX shift reg.
// TESTING
//  1 rst=1 mid-idle -> SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=8'h00.
//  2 start, tx_word=10'b00_1010_0101 -> SS_n low 11 cycles;
//    MOSI=0 then 0,0,1,0,1,0,0,1,0,1; done pulse; rd_valid stays 0.
//  3 start, tx_word=10'b11_0000_0000, MISO model drives 8'hC3 after 2-cycle turnaround
//    -> SS_n low 21 cycles; rd_data=8'hC3; rd_valid and done together.
//  4 start held high continuously -> second frame's SS_n falls exactly GAP cycles after FINISH;
//    start pulses while busy produce no extra frames.
//  5 rst=1 during SEND bit 5 -> SS_n=1 next cycle, no done; following frame bit-exact as in 2.
//  6 with spi slave + RAM: write addr 0x12, write data 0x5A, read addr 0x12, read data -> rd_data=8'h5A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and the SPI slave/RAM subsystem:
// frame geometry defaults, command codes and the master FSM state encoding.
package spi_pkg;

  localparam int FRAME_W_DEF    = 10;
  localparam int DATA_W_DEF     = 8;
  localparam int TURNAROUND_DEF = 2;
  localparam int GAP_DEF        = 1;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_TURN,
    ST_RECV,
    ST_FINISH,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_master.sv
// SPI master: shifts a command word out on MOSI MSB-first at one bit per clk and,
// for read-data frames, shifts a byte in from MISO after the slave's RAM turnaround.
module spi_master
  import spi_pkg::*;
#(
  parameter int FRAME_W    = FRAME_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TURNAROUND = TURNAROUND_DEF,
  parameter int GAP        = GAP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] tx_word,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  state_t             state, state_n;
  cmd_t               cmd, cmd_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [FRAME_W-1:0] tx_sr, tx_sr_n;
  logic [DATA_W-1:0]  rx_sr, rx_sr_n;
  logic [DATA_W-1:0]  rd_data_n;
  logic               ss_n_n, mosi_n, busy_n, done_n, rd_valid_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd      <= CMD_WR_ADDR;
      cnt      <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rd_data  <= '0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      cmd      <= cmd_n;
      cnt      <= cnt_n;
      tx_sr    <= tx_sr_n;
      rx_sr    <= rx_sr_n;
      rd_data  <= rd_data_n;
      SS_n     <= ss_n_n;
      MOSI     <= mosi_n;
      busy     <= busy_n;
      done     <= done_n;
      rd_valid <= rd_valid_n;
    end
  end

  // Outputs are computed for the state being entered, so each registered
  // output lines up with the cycle its state occupies.
  always_comb begin
    state_n    = state;
    cmd_n      = cmd;
    cnt_n      = cnt;
    tx_sr_n    = tx_sr;
    rx_sr_n    = rx_sr;
    rd_data_n  = rd_data;
    ss_n_n     = 1'b1;
    mosi_n     = 1'b0;
    busy_n     = 1'b1;
    done_n     = 1'b0;
    rd_valid_n = 1'b0;

    case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n = ST_START;
          tx_sr_n = tx_word;
          cmd_n   = cmd_t'(tx_word[FRAME_W-1 -: 2]);
          busy_n  = 1'b1;
          ss_n_n  = 1'b0;
          mosi_n  = tx_word[FRAME_W-1];
        end
      end

      ST_START: begin
        state_n = ST_SEND;
        cnt_n   = CNT_W'(FRAME_W - 1);
        ss_n_n  = 1'b0;
        mosi_n  = tx_sr[FRAME_W-1];
        tx_sr_n = {tx_sr[FRAME_W-2:0], 1'b0};
      end

      ST_SEND: begin
        if (cnt != '0) begin
          cnt_n   = cnt - 1'b1;
          ss_n_n  = 1'b0;
          mosi_n  = tx_sr[FRAME_W-1];
          tx_sr_n = {tx_sr[FRAME_W-2:0], 1'b0};
        end else if (cmd == CMD_RD_DATA) begin
          state_n = ST_TURN;
          cnt_n   = CNT_W'(TURNAROUND - 1);
          ss_n_n  = 1'b0;
        end else begin
          state_n = ST_FINISH;
          done_n  = 1'b1;
        end
      end

      ST_TURN: begin
        ss_n_n = 1'b0;
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = ST_RECV;
          cnt_n   = CNT_W'(DATA_W - 1);
        end
      end

      // MISO is only captured here; the last sample completes the byte.
      ST_RECV: begin
        rx_sr_n = {rx_sr[DATA_W-2:0], MISO};
        if (cnt != '0) begin
          cnt_n  = cnt - 1'b1;
          ss_n_n = 1'b0;
        end else begin
          state_n    = ST_FINISH;
          done_n     = 1'b1;
          rd_valid_n = 1'b1;
          rd_data_n  = {rx_sr[DATA_W-2:0], MISO};
        end
      end

      ST_FINISH: begin
        if (GAP > 1) begin
          state_n = ST_GAP;
          cnt_n   = CNT_W'(GAP - 2);
        end else begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
      end

      ST_GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
      end

      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
